div_64b_recon: RTL

Sequential reconstruction checker for the 64-bit divider: takes a quotient/remainder pair, the divisor, and the original dividend, rebuilds `quotient*divisor + remainder` with a radix-2 shift-add engine, and flags whether the pair is a valid division result. It sits on the far side of `div_64b` in the self-checking flow, consuming its outputs so that approximate divider variants can be scored in hardware rather than only from dumped text. It uses a valid/ready handshake on both sides, one transaction in flight.

---
 rtl/div_pkg.sv | 39 +++
 rtl/div_64b_recon_if.sv | 31 +++
 rtl/div_recon_acc.sv | 75 +++++++
 rtl/div_64b_recon.sv | 110 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 64-bit divider reconstruction checker:
// operand width, FSM state encoding, result bundle and result builder.
package div_pkg;

   localparam int DIV_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [2*DIV_W-1:0] recon;
      logic               ovf;
      logic               rem_ok;
      logic               match;
      logic               dz;
   } recon_t;

   // Turns a finished accumulator plus the latched operands into the full
   // verdict. For a zero divisor the accumulator holds just rem_in, so the
   // upper half is zero and ovf falls out as 0 naturally.
   function automatic recon_t build_result(
      input logic [2*DIV_W-1:0] acc,
      input logic [DIV_W-1:0]   divisor,
      input logic [DIV_W-1:0]   rem,
      input logic [DIV_W-1:0]   dividend
   );
      recon_t r;
      r.dz     = (divisor == {DIV_W{1'b0}});
      r.recon  = acc;
      r.ovf    = (acc[2*DIV_W-1:DIV_W] != {DIV_W{1'b0}});
      r.rem_ok = !r.dz && (rem < divisor);
      r.match  = !r.ovf && (acc[DIV_W-1:0] == dividend) && r.rem_ok;
      return r;
   endfunction

endpackage

// File: rtl/div_64b_recon_if.sv
// Handshake and data bundle between a divider-result producer (master)
// and the reconstruction checker (slave).
interface div_64b_recon_if
   import div_pkg::*;
#(
   parameter int W = DIV_W
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   quot;
   logic [W-1:0]   divisor;
   logic [W-1:0]   rem_in;
   logic [W-1:0]   dividend;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] recon;
   logic           ovf;
   logic           rem_ok;
   logic           match;
   logic           dz;

   modport master (
      output in_valid, quot, divisor, rem_in, dividend, out_ready,
      input  in_ready, out_valid, recon, ovf, rem_ok, match, dz
   );

   modport slave (
      input  in_valid, quot, divisor, rem_in, dividend, out_ready,
      output in_ready, out_valid, recon, ovf, rem_ok, match, dz
   );
endinterface

// File: rtl/div_recon_acc.sv
// Radix-2 shift-add datapath: acc starts at the remainder and absorbs one
// shifted copy of the divisor per set quotient bit, LSB first.
module div_recon_acc
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [W-1:0]   quot_i,
   input  logic [W-1:0]   divisor_i,
   input  logic [W-1:0]   rem_i,
   output logic [2*W-1:0] acc_nxt_o,
   output logic           last_o
);
   localparam int CW = $clog2(W);

   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] md_q, md_d;
   logic [W-1:0]   mq_q, mq_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] acc_step_s;

   // Accumulator value after one more iteration; also used by the top to
   // capture the final product on the same edge as the last step.
   always_comb begin
      if (mq_q[0]) begin
         acc_step_s = acc_q + md_q;
      end else begin
         acc_step_s = acc_q;
      end
   end

   // Next-state for load (new operands) and step (one shift-add iteration).
   always_comb begin
      acc_d = acc_q;
      mq_d  = mq_q;
      md_d  = md_q;
      cnt_d = cnt_q;
      if (load_i) begin
         acc_d = {{W{1'b0}}, rem_i};
         mq_d  = quot_i;
         md_d  = {{W{1'b0}}, divisor_i};
         cnt_d = {CW{1'b0}};
      end else if (step_i) begin
         acc_d = acc_step_s;
         mq_d  = {1'b0, mq_q[W-1:1]};
         md_d  = {md_q[2*W-2:0], 1'b0};
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         acc_d = acc_q;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= {(2*W){1'b0}};
         md_q  <= {(2*W){1'b0}};
         mq_q  <= {W{1'b0}};
         cnt_q <= {CW{1'b0}};
      end else begin
         acc_q <= acc_d;
         md_q  <= md_d;
         mq_q  <= mq_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_nxt_o = acc_step_s;
   assign last_o    = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/div_64b_recon.sv
// Reconstruction checker top: accepts a quotient/remainder pair, rebuilds
// quot*divisor + rem_in over W cycles and reports whether it reproduces the
// dividend. One transaction in flight; results held until the next one.
module div_64b_recon
   import div_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   div_64b_recon_if.slave bus
);
   localparam int W = DIV_W;

   state_t         state_q, state_d;
   logic [W-1:0]   divisor_q, divisor_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   dividend_q, dividend_d;
   recon_t         res_q, res_d;
   logic           load_s;
   logic           step_s;
   logic           last_s;
   logic [2*W-1:0] acc_nxt_s;

   div_recon_acc #(.W(W)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load_s),
      .step_i    (step_s),
      .quot_i    (bus.quot),
      .divisor_i (bus.divisor),
      .rem_i     (bus.rem_in),
      .acc_nxt_o (acc_nxt_s),
      .last_o    (last_s)
   );

   // FSM next state, operand capture and result capture on entry to DONE.
   always_comb begin
      state_d    = state_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      dividend_d = dividend_q;
      res_d      = res_q;
      load_s     = 1'b0;
      step_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               load_s     = 1'b1;
               divisor_d  = bus.divisor;
               rem_d      = bus.rem_in;
               dividend_d = bus.dividend;
               if (bus.divisor == {W{1'b0}}) begin
                  // Multiply skipped: the result is just the remainder.
                  state_d = ST_DONE;
                  res_d   = build_result({{W{1'b0}}, bus.rem_in}, bus.divisor,
                                         bus.rem_in, bus.dividend);
               end else begin
                  state_d = ST_MUL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            step_s = 1'b1;
            if (last_s) begin
               state_d = ST_DONE;
               res_d   = build_result(acc_nxt_s, divisor_q, rem_q, dividend_q);
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched operands and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         divisor_q  <= {W{1'b0}};
         rem_q      <= {W{1'b0}};
         dividend_q <= {W{1'b0}};
         res_q      <= {$bits(recon_t){1'b0}};
      end else begin
         state_q    <= state_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         dividend_q <= dividend_d;
         res_q      <= res_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.recon     = res_q.recon;
   assign bus.ovf       = res_q.ovf;
   assign bus.rem_ok    = res_q.rem_ok;
   assign bus.match     = res_q.match;
   assign bus.dz        = res_q.dz;

endmodule
